// File: rtl/hazard_unit.sv
// Table-free hazard unit for a 5-stage MIPS pipeline: Tuse/Tnew stall logic, forwarding selects, mult/div busy interlock.
// Optional stall statistics counter enabled by defining HAZARD_STAT_EN; otherwise stall_cnt is tied to zero.
module hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int TNEW_W     = 2,
    parameter int MD_MUL_CYC = 5,
    parameter int MD_DIV_CYC = 10,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic              e_md_start,
    input  logic              e_md_is_div,
    output logic              stall,
    output logic              md_busy,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic              fwd_m_rt,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam int MD_MAX = (MD_DIV_CYC > MD_MUL_CYC) ? MD_DIV_CYC : MD_MUL_CYC;
    localparam int MD_CW  = $clog2(MD_MAX + 1);

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;

    // Stage tracking state: destination and remaining Tnew as each instruction moves E -> M -> W.
    logic [REG_AW-1:0] e_dst, e_rs, e_rt;
    logic [TNEW_W-1:0] e_tnew;
    logic [REG_AW-1:0] m_dst, m_rt;
    logic [TNEW_W-1:0] m_tnew;
    logic [REG_AW-1:0] w_dst;
    logic [MD_CW-1:0]  md_cnt;

    logic haz_rs, haz_rt, haz_md;

    function automatic logic src_hazard(
        input logic              use_s,
        input logic [REG_AW-1:0] s,
        input logic [TNEW_W-1:0] tuse,
        input logic [REG_AW-1:0] ed,
        input logic [TNEW_W-1:0] et,
        input logic [REG_AW-1:0] md,
        input logic [TNEW_W-1:0] mt
    );
        return use_s && (s != '0) &&
               (((s == ed) && (tuse < et)) || ((s == md) && (tuse < mt)));
    endfunction

    // M wins over W because it holds the younger write to the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] s,
        input logic [REG_AW-1:0] md,
        input logic [TNEW_W-1:0] mt,
        input logic [REG_AW-1:0] wd
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if ((s != '0) && (s == md) && (mt == '0)) begin
            sel = FWD_M;
        end else if ((s != '0) && (s == wd)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    always_comb begin
        haz_rs   = src_hazard(d_use_rs, d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
        haz_rt   = src_hazard(d_use_rt, d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
        md_busy  = e_md_start || (md_cnt != '0);
        haz_md   = d_md_use && md_busy;
        stall    = !reset && (haz_rs || haz_rt || haz_md);
        fwd_d_rs = fwd_sel(d_rs, m_dst, m_tnew, w_dst);
        fwd_d_rt = fwd_sel(d_rt, m_dst, m_tnew, w_dst);
        fwd_e_rs = fwd_sel(e_rs, m_dst, m_tnew, w_dst);
        fwd_e_rt = fwd_sel(e_rt, m_dst, m_tnew, w_dst);
        fwd_m_rt = (m_rt != '0) && (m_rt == w_dst);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values of the previous one.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst  <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            m_rt   <= '0;
            w_dst  <= '0;
        end else begin
            if (stall) begin
                e_dst  <= '0;
                e_tnew <= '0;
                e_rs   <= '0;
                e_rt   <= '0;
            end else begin
                e_dst  <= d_dst;
                e_tnew <= d_tnew;
                e_rs   <= d_use_rs ? d_rs : '0;
                e_rt   <= d_use_rt ? d_rt : '0;
            end
            m_dst  <= e_dst;
            m_tnew <= sat_dec(e_tnew);
            m_rt   <= e_rt;
            w_dst  <= m_dst;
        end
    end

    // A start while the unit is already counting is ignored rather than reloading.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (e_md_start && (md_cnt == '0)) begin
            md_cnt <= e_md_is_div ? MD_CW'(MD_DIV_CYC) : MD_CW'(MD_MUL_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_CW'(1);
        end
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STAT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: load-use, branch, store, mult/div interlock, $0 and reset cases.
// A second instance with a 2-bit statistics counter exercises saturation when HAZARD_STAT_EN is defined.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic       d_use_rs, d_use_rt, d_md_use;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       e_md_start, e_md_is_div;

    logic        stall, md_busy, fwd_m_rt;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [31:0] stall_cnt;

    logic        s_stall, s_md_busy, s_fwd_m_rt;
    logic [1:0]  s_fwd_d_rs, s_fwd_d_rt, s_fwd_e_rs, s_fwd_e_rt;
    logic [1:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;
    int stalls;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_use(d_md_use), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .stall(stall), .md_busy(md_busy),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .fwd_m_rt(fwd_m_rt), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.STAT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_use(d_md_use), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .stall(s_stall), .md_busy(s_md_busy),
        .fwd_d_rs(s_fwd_d_rs), .fwd_d_rt(s_fwd_d_rt), .fwd_e_rs(s_fwd_e_rs), .fwd_e_rt(s_fwd_e_rt),
        .fwd_m_rt(s_fwd_m_rt), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_d(input logic [4:0] rs, input logic use_rs, input logic [1:0] tuse_rs,
                           input logic [4:0] rt, input logic use_rt, input logic [1:0] tuse_rt,
                           input logic [4:0] dst, input logic [1:0] tnew, input logic md_use);
        d_rs = rs; d_use_rs = use_rs; d_tuse_rs = tuse_rs;
        d_rt = rt; d_use_rt = use_rt; d_tuse_rt = tuse_rt;
        d_dst = dst; d_tnew = tnew; d_md_use = md_use;
    endtask

    task automatic nop();
        drive_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_busy"}, {31'd0, md_busy}, 32'd0);
        check({tag, "_fwd"}, {23'd0, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        e_md_start = 1'b0;
        e_md_is_div = 1'b0;
        nop();
        repeat (2) tick();
        settle();
        check_all_zero("in_reset");
        tick();
        reset = 1'b0;
        settle();
        check_all_zero("post_reset");
        check("post_reset_cnt", stall_cnt, 32'd0);
        tick();

        // lw $1 then addu $3,$1,$2
        drive_d(5'd10, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd1, 2'd2, 1'b0);
        settle();
        check("lw_stall", {31'd0, stall}, 32'd0);
        tick();
        drive_d(5'd1, 1'b1, 2'd1, 5'd2, 1'b1, 2'd1, 5'd3, 2'd1, 1'b0);
        settle();
        check("lu_stall1", {31'd0, stall}, 32'd1);
        check("sat_inst_match", {23'd0, s_stall, s_md_busy, s_fwd_d_rs, s_fwd_d_rt, s_fwd_e_rs, s_fwd_e_rt},
              {23'd0, stall, md_busy, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
        check("sat_inst_mrt", {31'd0, s_fwd_m_rt}, {31'd0, fwd_m_rt});
        tick();
        settle();
        check("lu_stall2", {31'd0, stall}, 32'd0);
        check("lu_fwd_d_rs", {30'd0, fwd_d_rs}, 32'd0);
        tick();
        nop();
        settle();
        check("lu_fwd_e_rs", {30'd0, fwd_e_rs}, 32'd2);
        check("lu_fwd_e_rt", {30'd0, fwd_e_rt}, 32'd0);
        tick();
        drain();

        // addu $1 then beq $1,$2
        drive_d(5'd4, 1'b1, 2'd1, 5'd5, 1'b1, 2'd1, 5'd1, 2'd1, 1'b0);
        settle();
        check("alu_stall", {31'd0, stall}, 32'd0);
        tick();
        drive_d(5'd1, 1'b1, 2'd0, 5'd2, 1'b1, 2'd0, 5'd0, 2'd0, 1'b0);
        settle();
        check("beq_stall1", {31'd0, stall}, 32'd1);
        tick();
        settle();
        check("beq_stall2", {31'd0, stall}, 32'd0);
        check("beq_fwd_d_rs", {30'd0, fwd_d_rs}, 32'd1);
        check("beq_fwd_d_rt", {30'd0, fwd_d_rt}, 32'd0);
        tick();
        drain();

        // ori $1,$0 then sw $1,0($5)
        drive_d(5'd0, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd1, 2'd1, 1'b0);
        settle();
        check("ori_stall", {31'd0, stall}, 32'd0);
        tick();
        drive_d(5'd5, 1'b1, 2'd1, 5'd1, 1'b1, 2'd2, 5'd0, 2'd0, 1'b0);
        settle();
        check("sw_stall", {31'd0, stall}, 32'd0);
        tick();
        nop();
        settle();
        check("sw_fwd_e_rt", {30'd0, fwd_e_rt}, 32'd1);
        check("sw_fwd_e_rs", {30'd0, fwd_e_rs}, 32'd0);
        tick();
        settle();
        check("sw_fwd_m_rt", {31'd0, fwd_m_rt}, 32'd1);
        tick();
        drain();

        // lw $6; mult $6,$7; mflo $4
        drive_d(5'd10, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd6, 2'd2, 1'b0);
        tick();
        drive_d(5'd6, 1'b1, 2'd1, 5'd7, 1'b1, 2'd1, 5'd0, 2'd0, 1'b1);
        settle();
        check("mult_lu_stall", {31'd0, stall}, 32'd1);
        tick();
        settle();
        check("mult_go", {31'd0, stall}, 32'd0);
        check("mult_idle", {31'd0, md_busy}, 32'd0);
        tick();
        drive_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd4, 2'd1, 1'b1);
        e_md_start = 1'b1;
        e_md_is_div = 1'b0;
        settle();
        check("mult_busy", {31'd0, md_busy}, 32'd1);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            if (!stall) break;
            stalls++;
            tick();
            e_md_start = 1'b0;
            settle();
        end
        check("mflo_stall_cycles", stalls, 32'd6);
        check("mult_done", {31'd0, md_busy}, 32'd0);
        tick();
        drain();

`ifdef HAZARD_STAT_EN
        check("stat_total", stall_cnt, 32'd9);
        check("stat_saturate", {30'd0, s_stall_cnt}, 32'd3);
`else
        check("stat_off", stall_cnt, 32'd0);
        check("stat_off_sat", {30'd0, s_stall_cnt}, 32'd0);
`endif

        // writer of $0 then reader of $0
        drive_d(5'd10, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd0, 2'd2, 1'b0);
        tick();
        drive_d(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd9, 2'd1, 1'b0);
        settle();
        check_all_zero("zero_d");
        tick();
        nop();
        settle();
        check_all_zero("zero_e");
        tick();
        settle();
        check_all_zero("zero_m");
        tick();
        drain();

        // div started, dependent instr stalls, reset mid-div
        drive_d(5'd10, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd7, 2'd2, 1'b0);
        e_md_start = 1'b1;
        e_md_is_div = 1'b1;
        settle();
        check("div_busy", {31'd0, md_busy}, 32'd1);
        check("div_nostall", {31'd0, stall}, 32'd0);
        tick();
        e_md_start = 1'b0;
        drive_d(5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd8, 2'd1, 1'b1);
        settle();
        check("div_stall", {31'd0, stall}, 32'd1);
        check("div_busy2", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_forces_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b0;
        settle();
        check_all_zero("after_reset");
        check("after_reset_cnt", stall_cnt, 32'd0);
        tick();
        settle();
        check("after_reset_busy", {31'd0, md_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
